preg_ready_table: RTL and testbench

Tracks, for every physical register, whether its value has been produced. It lets dispatch mark each source operand as ready or not before the instruction is written into the ALU, memory, branch or mult issue queues. It sits between rename/dispatch and the issue queues:
- It sets a register busy when dispatch allocates it as a destination.
- It clears it when the same wakeup broadcast that the issue queues snoop arrives.
- It returns per-source ready bits that become the `src_data_t.valid` field of each `write_req_t`.

---
 rtl/preg_ready_table.sv | 144 ++++++++++++++
 tb/tb_preg_ready_table.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/preg_ready_table.sv
// Physical-register ready scoreboard: one busy bit per preg, set on dispatch
// allocation, cleared by the issue-queue wake bus, with same-cycle wake bypass.

package preg_ready_table_pkg;
  localparam int PREG_NUM  = 64;
  localparam int PREG_W    = $clog2(PREG_NUM);
  localparam int WRITE_NUM = 2;
  localparam int WAKE_NUM  = 4;
  localparam int CNT_W     = $clog2(PREG_NUM) + 1;

  typedef logic [PREG_W-1:0] preg_addr_t;

  typedef struct packed {
    logic       valid;
    preg_addr_t id;
  } wake_req_t;
endpackage

module preg_ready_table_chk
  import preg_ready_table_pkg::*;
(
  input logic                       clk,
  input logic                       resetn,
  input logic       [WRITE_NUM-1:0] alloc_valid,
  input preg_addr_t [WRITE_NUM-1:0] alloc_dst
);

  logic dup_alloc_s;

  // Two valid slots naming the same non-zero destination in one cycle
  always_comb begin
    dup_alloc_s = 1'b0;
    for (int i = 0; i < WRITE_NUM; i++) begin
      for (int j = 0; j < i; j++) begin
        dup_alloc_s = dup_alloc_s | (alloc_valid[i] & alloc_valid[j] &
                      (alloc_dst[i] == alloc_dst[j]) &
                      (alloc_dst[i] != {PREG_W{1'b0}}));
      end
    end
  end

  a_no_dup_alloc: assert property (@(posedge clk) disable iff (!resetn) !dup_alloc_s);

endmodule

module preg_ready_table
  import preg_ready_table_pkg::*;
(
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       flush,
  input  logic       [WRITE_NUM-1:0] alloc_valid,
  input  preg_addr_t [WRITE_NUM-1:0] alloc_dst,
  input  preg_addr_t [WRITE_NUM-1:0] query_src1,
  input  preg_addr_t [WRITE_NUM-1:0] query_src2,
  output logic       [WRITE_NUM-1:0] src1_ready,
  output logic       [WRITE_NUM-1:0] src2_ready,
  input  wake_req_t  [WAKE_NUM-1:0]  wake,
  output logic       [CNT_W-1:0]     busy_count
);

  logic [PREG_NUM-1:0] busy_r;
  logic [PREG_NUM-1:0] busy_nxt_s;
  logic [PREG_NUM-1:0] wake_hit_s;
  logic [PREG_NUM-1:0] alloc_hit_s;

  function automatic logic [CNT_W-1:0] popcount(input logic [PREG_NUM-1:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = {CNT_W{1'b0}};
    for (int k = 0; k < PREG_NUM; k++) begin
      cnt = cnt + {{(CNT_W-1){1'b0}}, v[k]};
    end
    return cnt;
  endfunction

  // Decode the wake bus and the allocation slots into per-preg hit vectors
  always_comb begin
    wake_hit_s  = {PREG_NUM{1'b0}};
    alloc_hit_s = {PREG_NUM{1'b0}};
    for (int w = 0; w < WAKE_NUM; w++) begin
      wake_hit_s[wake[w].id] = wake_hit_s[wake[w].id] | wake[w].valid;
    end
    for (int i = 0; i < WRITE_NUM; i++) begin
      alloc_hit_s[alloc_dst[i]] = alloc_hit_s[alloc_dst[i]] | alloc_valid[i];
    end
    alloc_hit_s[0] = 1'b0;
  end

  // Next busy vector: flush, then allocate (a same-cycle wake is stale), then wake
  always_comb begin
    busy_nxt_s = busy_r;
    for (int p = 0; p < PREG_NUM; p++) begin
      if (flush) begin
        busy_nxt_s[p] = 1'b0;
      end else if (alloc_hit_s[p]) begin
        busy_nxt_s[p] = 1'b1;
      end else if (wake_hit_s[p]) begin
        busy_nxt_s[p] = 1'b0;
      end else begin
        busy_nxt_s[p] = busy_r[p];
      end
    end
    busy_nxt_s[0] = 1'b0;
  end

  // Per-slot source lookup; an older slot's destination in this group forces not-ready
  always_comb begin
    logic intra1_s;
    logic intra2_s;
    src1_ready = {WRITE_NUM{1'b0}};
    src2_ready = {WRITE_NUM{1'b0}};
    for (int i = 0; i < WRITE_NUM; i++) begin
      intra1_s = 1'b0;
      intra2_s = 1'b0;
      for (int j = 0; j < i; j++) begin
        intra1_s = intra1_s | (alloc_valid[j] & (alloc_dst[j] == query_src1[i]));
        intra2_s = intra2_s | (alloc_valid[j] & (alloc_dst[j] == query_src2[i]));
      end
      src1_ready[i] = (query_src1[i] == {PREG_W{1'b0}}) |
                      ((~busy_r[query_src1[i]] | wake_hit_s[query_src1[i]]) & ~intra1_s);
      src2_ready[i] = (query_src2[i] == {PREG_W{1'b0}}) |
                      ((~busy_r[query_src2[i]] | wake_hit_s[query_src2[i]]) & ~intra2_s);
    end
  end

  // Busy state and its population count
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_r     <= {PREG_NUM{1'b0}};
      busy_count <= {CNT_W{1'b0}};
    end else begin
      busy_r     <= busy_nxt_s;
      busy_count <= popcount(busy_nxt_s);
    end
  end

  preg_ready_table_chk u_chk (
    .clk         (clk),
    .resetn      (resetn),
    .alloc_valid (alloc_valid),
    .alloc_dst   (alloc_dst)
  );

endmodule

// File: tb/tb_preg_ready_table.sv
// Directed bench for preg_ready_table: alloc, wake bypass, intra-group hazards,
// flush, preg 0 handling and asynchronous reset.

module tb_preg_ready_table;
  import preg_ready_table_pkg::*;

  logic                       clk;
  logic                       resetn;
  logic                       flush;
  logic       [WRITE_NUM-1:0] alloc_valid;
  preg_addr_t [WRITE_NUM-1:0] alloc_dst;
  preg_addr_t [WRITE_NUM-1:0] query_src1;
  preg_addr_t [WRITE_NUM-1:0] query_src2;
  logic       [WRITE_NUM-1:0] src1_ready;
  logic       [WRITE_NUM-1:0] src2_ready;
  wake_req_t  [WAKE_NUM-1:0]  wake;
  logic       [CNT_W-1:0]     busy_count;

  int errors = 0;
  int checks = 0;

  preg_ready_table dut (
    .clk         (clk),
    .resetn      (resetn),
    .flush       (flush),
    .alloc_valid (alloc_valid),
    .alloc_dst   (alloc_dst),
    .query_src1  (query_src1),
    .query_src2  (query_src2),
    .src1_ready  (src1_ready),
    .src2_ready  (src2_ready),
    .wake        (wake),
    .busy_count  (busy_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    flush       = 1'b0;
    alloc_valid = '0;
    alloc_dst   = '0;
    query_src1  = '0;
    query_src2  = '0;
    wake        = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;

    // Reset state: 5 and 0 queried in both slots
    query_src1[0] = 6'd5; query_src1[1] = 6'd5;
    query_src2[0] = 6'd0; query_src2[1] = 6'd0;
    #1;
    chk("reset_src1", 32'(src1_ready), 32'h3);
    chk("reset_src2", 32'(src2_ready), 32'h3);
    chk("reset_count", 32'(busy_count), 32'd0);

    // Alloc 7 in slot0; slot1 sees the intra-group hazard, slot0 does not see its own dst
    tick(); idle();
    alloc_valid[0] = 1'b1; alloc_dst[0] = 6'd7;
    query_src1[0] = 6'd7; query_src1[1] = 6'd7;
    #1;
    chk("intra_src1", 32'(src1_ready), 32'h1);
    tick(); idle();
    query_src1[0] = 6'd7;
    #1;
    chk("busy7_ready", 32'(src1_ready[0]), 32'd0);
    chk("busy7_count", 32'(busy_count), 32'd1);
    wake[0] = '{valid: 1'b1, id: 6'd7};
    #1;
    chk("bypass7_ready", 32'(src1_ready[0]), 32'd1);
    tick(); idle();
    query_src1[0] = 6'd7;
    #1;
    chk("state7_ready", 32'(src1_ready[0]), 32'd1);
    chk("state7_count", 32'(busy_count), 32'd0);

    // Alloc 9 with concurrent wake 9: slot1 not ready, 9 stays busy
    idle();
    alloc_valid[0] = 1'b1; alloc_dst[0] = 6'd9;
    query_src2[1] = 6'd9;
    wake[1] = '{valid: 1'b1, id: 6'd9};
    #1;
    chk("alloc_wake9_src2", 32'(src2_ready[1]), 32'd0);
    tick(); idle();
    query_src1[0] = 6'd9;
    #1;
    chk("busy9_ready", 32'(src1_ready[0]), 32'd0);
    chk("busy9_count", 32'(busy_count), 32'd1);
    wake[3] = '{valid: 1'b1, id: 6'd9};
    tick(); idle();
    #1;
    chk("clear9_count", 32'(busy_count), 32'd0);

    // Alloc 3,4 then 5, then flush with alloc 6
    alloc_valid = 2'b11; alloc_dst[0] = 6'd3; alloc_dst[1] = 6'd4;
    tick(); idle();
    alloc_valid[0] = 1'b1; alloc_dst[0] = 6'd5;
    tick(); idle();
    #1;
    chk("pre_flush_count", 32'(busy_count), 32'd3);
    flush = 1'b1;
    alloc_valid[0] = 1'b1; alloc_dst[0] = 6'd6;
    query_src1[0] = 6'd3; query_src1[1] = 6'd4;
    #1;
    chk("flush_cycle_src1", 32'(src1_ready), 32'h0);
    tick(); idle();
    query_src1[0] = 6'd3; query_src1[1] = 6'd4;
    query_src2[0] = 6'd5; query_src2[1] = 6'd6;
    #1;
    chk("post_flush_src1", 32'(src1_ready), 32'h3);
    chk("post_flush_src2", 32'(src2_ready), 32'h3);
    chk("post_flush_count", 32'(busy_count), 32'd0);

    // Duplicate wake of 12 on ports 0 and 2 clears it exactly once
    alloc_valid = 2'b11; alloc_dst[0] = 6'd12; alloc_dst[1] = 6'd13;
    tick(); idle();
    #1;
    chk("busy12_13_count", 32'(busy_count), 32'd2);
    wake[0] = '{valid: 1'b1, id: 6'd12};
    wake[2] = '{valid: 1'b1, id: 6'd12};
    query_src1[1] = 6'd12;
    #1;
    chk("dup_wake_bypass", 32'(src1_ready[1]), 32'd1);
    tick(); idle();
    query_src1[1] = 6'd12; query_src2[1] = 6'd13;
    #1;
    chk("dup_wake_count", 32'(busy_count), 32'd1);
    chk("dup_wake_ready12", 32'(src1_ready[1]), 32'd1);
    chk("dup_wake_ready13", 32'(src2_ready[1]), 32'd0);
    wake[1] = '{valid: 1'b1, id: 6'd13};
    tick(); idle();
    #1;
    chk("clear13_count", 32'(busy_count), 32'd0);

    // Allocating preg 0 is ignored
    alloc_valid[1] = 1'b1; alloc_dst[1] = 6'd0;
    tick(); idle();
    query_src1[0] = 6'd0; query_src2[1] = 6'd0;
    #1;
    chk("preg0_count", 32'(busy_count), 32'd0);
    chk("preg0_src1", 32'(src1_ready[0]), 32'd1);
    chk("preg0_src2", 32'(src2_ready[1]), 32'd1);

    // Asynchronous reset mid-cycle with alloc 20 pending and 21 busy
    alloc_valid[0] = 1'b1; alloc_dst[0] = 6'd21;
    tick(); idle();
    alloc_valid[0] = 1'b1; alloc_dst[0] = 6'd20;
    query_src1[0] = 6'd21; query_src1[1] = 6'd20;
    #1;
    chk("pre_rst_count", 32'(busy_count), 32'd1);
    chk("pre_rst_src1", 32'(src1_ready), 32'h0);
    #1;
    resetn = 1'b0;
    #1;
    chk("rst_async_count", 32'(busy_count), 32'd0);
    chk("rst_async_src1_0", 32'(src1_ready[0]), 32'd1);
    @(posedge clk);
    #1;
    alloc_valid = '0;
    resetn = 1'b1;
    #1;
    chk("post_rst_src1", 32'(src1_ready), 32'h3);
    chk("post_rst_count", 32'(busy_count), 32'd0);
    tick();
    chk("post_rst_count2", 32'(busy_count), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
